// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// req/gnt handshake for the address phase, rvalid/rdata for load return.
//   dm_req    master -> slave  request valid
//   dm_we     master -> slave  1 = store
//   dm_addr   master -> slave  byte address
//   dm_wdata  master -> slave  store data
//   dm_gnt    slave -> master  request accepted this cycle
//   dm_rvalid slave -> master  read data valid
//   dm_rdata  slave -> master  read data
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// LEGv8 MEM stage: EX/MEM pipeline register, variable-latency data-memory
// access with timeout, MEM-side forwarding and registered MEM/WB outputs.
//   clk, reset            clock, asynchronous active-low reset
//   in_valid, *_in        EX-stage outputs, captured when stall=0
//   stall                 upstream hold while an access is in flight
//   MEM_*, EX_MEM_Rd      forwarding from the EX/MEM register
//   dm                    data-memory bus (master side)
//   wb_*                  MEM/WB register
//   mem_err               sticky timeout flag
module mem_stage #(
  parameter int unsigned TIMEOUT   = 15,
  parameter logic [63:0] RST_PC_BL = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic        BrLink_in,
  input  logic [4:0]  Rd_in,
  input  logic [63:0] ALU_Result_in,
  input  logic [63:0] Read_Data2_in,
  input  logic [63:0] PC_BL_in,
  output logic        stall,
  output logic [63:0] MEM_ALUResult,
  output logic [4:0]  EX_MEM_Rd,
  output logic        MEM_RegWrite,
  output logic        MEM_MemWrite,
  output logic        MEM_BrLink,
  mem_stage_if.master dm,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_Rd,
  output logic [63:0] wb_data,
  output logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;

  // EX/MEM register
  logic        v_q, rw_q, mr_q, mw_q, m2r_q, bl_q;
  logic [4:0]  rd_q;
  logic [63:0] alu_q, wd_q, pc_q;

  logic        rw_ok, non_mem, done, expire;
  logic [63:0] wb_sel;

  always_comb begin
    rw_ok   = rw_q & (rd_q != 5'd31);
    non_mem = v_q & ~(mr_q | mw_q);
    wb_sel  = bl_q ? pc_q : (m2r_q ? dm.dm_rdata : alu_q);
    unique case (state_q)
      StReq:   done = dm.dm_gnt & (mw_q | dm.dm_rvalid);
      StWait:  done = dm.dm_rvalid;
      default: done = 1'b0;
    endcase
    // A real completion in the final allowed cycle wins over the abort.
    expire = (state_q != StIdle) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);
  end

  assign stall         = (state_q != StIdle);
  assign dm.dm_req     = (state_q == StReq);
  assign dm.dm_we      = (state_q == StReq) & mw_q;
  assign dm.dm_addr    = alu_q;
  assign dm.dm_wdata   = wd_q;
  assign MEM_ALUResult = alu_q;
  assign EX_MEM_Rd     = rd_q;
  assign MEM_RegWrite  = v_q & rw_ok;
  assign MEM_MemWrite  = v_q & mw_q;
  assign MEM_BrLink    = v_q & bl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      v_q         <= 1'b0;
      rw_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      bl_q        <= 1'b0;
      rd_q        <= '0;
      alu_q       <= RST_PC_BL;
      wd_q        <= RST_PC_BL;
      pc_q        <= RST_PC_BL;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_Rd       <= '0;
      wb_data     <= RST_PC_BL;
      mem_err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Non-memory ops retire one cycle after capture; a memory op left
          // over from a finished access was already retired and must not be.
          wb_valid    <= non_mem;
          wb_RegWrite <= non_mem & rw_ok;
          if (non_mem) begin
            wb_Rd   <= rd_q;
            wb_data <= wb_sel;
          end
          v_q   <= in_valid;
          rw_q  <= RegWrite_in;
          mr_q  <= MemRead_in;
          mw_q  <= MemWrite_in;
          m2r_q <= MemtoReg_in;
          bl_q  <= BrLink_in;
          rd_q  <= Rd_in;
          alu_q <= ALU_Result_in;
          wd_q  <= Read_Data2_in;
          pc_q  <= PC_BL_in;
          cnt_q <= '0;
          if (in_valid && (MemRead_in || MemWrite_in)) begin
            state_q <= StReq;
          end
        end
        default: begin
          cnt_q       <= cnt_q + 16'd1;
          wb_valid    <= 1'b0;
          wb_RegWrite <= 1'b0;
          if (done) begin
            state_q     <= StIdle;
            wb_valid    <= 1'b1;
            wb_RegWrite <= rw_ok;
            wb_Rd       <= rd_q;
            wb_data     <= wb_sel;
          end else if (expire) begin
            state_q  <= StIdle;
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_Rd    <= rd_q;
            wb_data  <= '0;
          end else if (state_q == StReq && dm.dm_gnt) begin
            state_q <= StWait;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [63:0] RST_V   = 64'h0;

  typedef struct packed {
    logic        rw, mr, mw, m2r, bl;
    logic [4:0]  rd;
    logic [63:0] alu, rd2, pcbl;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, RegWrite_in, MemRead_in, MemWrite_in, MemtoReg_in, BrLink_in;
  logic [4:0]  Rd_in;
  logic [63:0] ALU_Result_in, Read_Data2_in, PC_BL_in;
  logic        stall, MEM_RegWrite, MEM_MemWrite, MEM_BrLink;
  logic [63:0] MEM_ALUResult;
  logic [4:0]  EX_MEM_Rd;
  logic        wb_valid, wb_RegWrite, mem_err;
  logic [4:0]  wb_Rd;
  logic [63:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;
  bit err_m = 0;   // reference copy of the sticky error flag

  mem_stage_if dmi ();

  mem_stage #(.TIMEOUT(TIMEOUT), .RST_PC_BL(RST_V)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemtoReg_in(MemtoReg_in), .BrLink_in(BrLink_in), .Rd_in(Rd_in),
    .ALU_Result_in(ALU_Result_in), .Read_Data2_in(Read_Data2_in), .PC_BL_in(PC_BL_in),
    .stall(stall), .MEM_ALUResult(MEM_ALUResult), .EX_MEM_Rd(EX_MEM_Rd),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite), .MEM_BrLink(MEM_BrLink),
    .dm(dmi), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 ALU op, 1 load, 2 store, 3 branch-and-link, 4 no register write
  function automatic instr_t mk(input int kind, input logic [4:0] rd, input logic [63:0] alu,
                                input logic [63:0] rd2, input logic [63:0] pcbl);
    instr_t i;
    i = '0;
    i.rd = rd; i.alu = alu; i.rd2 = rd2; i.pcbl = pcbl;
    case (kind)
      0: i.rw = 1'b1;
      1: begin i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; end
      2: i.mw = 1'b1;
      3: begin i.rw = 1'b1; i.bl = 1'b1; end
      default: ;
    endcase
    return i;
  endfunction

  function automatic instr_t rand_instr();
    return mk($urandom_range(0, 4), 5'($urandom_range(0, 31)), {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
  endfunction

  task automatic drive(input instr_t i, input logic v);
    in_valid = v; RegWrite_in = i.rw; MemRead_in = i.mr; MemWrite_in = i.mw;
    MemtoReg_in = i.m2r; BrLink_in = i.bl; Rd_in = i.rd;
    ALU_Result_in = i.alu; Read_Data2_in = i.rd2; PC_BL_in = i.pcbl;
  endtask

  // Bubble with random payload: nothing in it may take effect.
  task automatic bubble();
    drive(rand_instr(), 1'b0);
  endtask

  // Issue one instruction at the current negedge. g = REQ cycles without grant,
  // r = cycles from grant to rvalid (0 = same cycle). Returns at a negedge with
  // a bubble on the inputs and the stage idle.
  task automatic run_instr(input instr_t i, input int g, input int r, input logic [63:0] rdata);
    bit mem, load, abort;
    int c, tend;
    logic [63:0] exp_data;
    mem  = i.mr | i.mw;
    load = i.mr & ~i.mw;
    exp_data = i.bl ? i.pcbl : (i.m2r ? rdata : i.alu);
    drive(i, 1'b1);
    @(negedge clk);
    chk("fwd_alu", MEM_ALUResult, i.alu);
    chk("fwd_rd", EX_MEM_Rd, i.rd);
    chk("fwd_rw", MEM_RegWrite, i.rw & (i.rd != 5'd31));
    chk("fwd_mw", MEM_MemWrite, i.mw);
    chk("fwd_bl", MEM_BrLink, i.bl);
    if (!mem) begin
      chk("alu_stall", stall, 1'b0);
      chk("alu_req", dmi.dm_req, 1'b0);
      bubble();
      @(negedge clk);
      chk("alu_wb_valid", wb_valid, 1'b1);
      chk("alu_wb_rw", wb_RegWrite, i.rw & (i.rd != 5'd31));
      chk("alu_wb_rd", wb_Rd, i.rd);
      chk("alu_wb_data", wb_data, exp_data);
      chk("bubble_fwd_rw", MEM_RegWrite, 1'b0);
      chk("bubble_stall", stall, 1'b0);
    end else begin
      c     = load ? g + 1 + r : g + 1;
      abort = (c > int'(TIMEOUT));
      tend  = abort ? int'(TIMEOUT) : c;
      for (int k = 1; k <= tend; k++) begin
        if (k > 1) @(negedge clk);
        chk("mem_stall", stall, 1'b1);
        chk("mem_req", dmi.dm_req, (k <= g + 1));
        if (k <= g + 1) begin
          chk("mem_we", dmi.dm_we, i.mw);
          chk("mem_addr", dmi.dm_addr, i.alu);
          if (i.mw) chk("mem_wdata", dmi.dm_wdata, i.rd2);
        end
        chk("mem_fwd_hold", MEM_ALUResult, i.alu);
        dmi.dm_gnt    = (k == g + 1);
        dmi.dm_rvalid = (load && k == c) || (k <= g && $urandom_range(0, 2) == 0);
        dmi.dm_rdata  = (k == c) ? rdata : {$urandom, $urandom};
      end
      @(negedge clk);
      dmi.dm_gnt = 1'b0;
      dmi.dm_rvalid = 1'b0;
      if (abort) err_m = 1'b1;
      chk("done_stall", stall, 1'b0);
      chk("done_wb_valid", wb_valid, 1'b1);
      chk("done_wb_rw", wb_RegWrite, abort ? 1'b0 : (i.rw & (i.rd != 5'd31)));
      chk("done_wb_rd", wb_Rd, i.rd);
      chk("done_wb_data", wb_data, abort ? 64'h0 : exp_data);
      chk("done_err", mem_err, err_m);
      bubble();
      @(negedge clk);
      chk("after_wb_valid", wb_valid, 1'b0);
      chk("after_fwd_rw", MEM_RegWrite, 1'b0);
      chk("after_stall", stall, 1'b0);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_req"}, dmi.dm_req, 1'b0);
    chk({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk({tag, "_wb_rw"}, wb_RegWrite, 1'b0);
    chk({tag, "_err"}, mem_err, 1'b0);
    chk({tag, "_fwd_rw"}, MEM_RegWrite, 1'b0);
  endtask

  initial begin
    instr_t i;
    int g, r;
    reset = 1'b0;
    drive('0, 1'b0);
    dmi.dm_gnt = 1'b0; dmi.dm_rvalid = 1'b0; dmi.dm_rdata = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    chk("rst_wb_data", wb_data, RST_V);
    chk("rst_fwd_alu", MEM_ALUResult, RST_V);
    chk("rst_fwd_rd", EX_MEM_Rd, 5'd0);
    reset = 1'b1;
    @(negedge clk);

    // ADD X3, LDUR X5 (grant in 2nd cycle, data 3 cycles later), STUR
    run_instr(mk(0, 5'd3, 64'h10, 64'h0, 64'h0), 0, 0, 64'h0);
    run_instr(mk(1, 5'd5, 64'h40, 64'h0, 64'h0), 1, 3, 64'hDEAD_BEEF);
    run_instr(mk(2, 5'd9, 64'h48, 64'h1234_5678, 64'h0), 0, 0, 64'h0);

    // Reset in the middle of REQ: request must drop without a clock edge
    drive(mk(1, 5'd7, 64'h80, 64'h0, 64'h0), 1'b1);
    @(negedge clk);
    chk("pre_rst_req", dmi.dm_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_req", dmi.dm_req, 1'b0);
    chk("async_stall", stall, 1'b0);
    bubble();
    @(negedge clk);
    reset = 1'b1;

    // Timeout, then normal ALU op, then BL into X30 and X31
    run_instr(mk(1, 5'd6, 64'h50, 64'h0, 64'h0), TIMEOUT + 4, 0, 64'h0);
    run_instr(mk(0, 5'd3, 64'h22, 64'h0, 64'h0), 0, 0, 64'h0);
    chk("err_sticky", mem_err, 1'b1);
    run_instr(mk(3, 5'd30, 64'h77, 64'h0, 64'h100), 0, 0, 64'h0);
    run_instr(mk(3, 5'd31, 64'h77, 64'h0, 64'h100), 0, 0, 64'h0);

    // Reset during WAIT with mem_err set
    drive(mk(1, 5'd5, 64'h40, 64'h0, 64'h0), 1'b1);
    @(negedge clk);
    dmi.dm_gnt = 1'b1;
    @(negedge clk);
    dmi.dm_gnt = 1'b0;
    chk("wait_stall", stall, 1'b1);
    chk("wait_req", dmi.dm_req, 1'b0);
    reset = 1'b0;
    #1;
    err_m = 1'b0;
    chk_reset_state("rst_wait");
    bubble();
    @(negedge clk);
    reset = 1'b1;
    run_instr(mk(1, 5'd5, 64'h40, 64'h0, 64'h0), 1, 3, 64'hDEAD_BEEF);

    // Randomized sequence
    for (int n = 0; n < 40; n++) begin
      i = rand_instr();
      g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 5))
                                      : int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 4));
      run_instr(i, g, r, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    chk("final_err", mem_err, err_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
